// File: rtl/wb_stage_if.sv
// Write-back stage bus: upstream result handshake, retire/GPR write port and IDU scoreboard query.
interface wb_stage_if #(
    parameter int ISA_WIDTH = 32,
    parameter int REG_ADDR  = 5,
    parameter int REG_NUM   = 32
);
    logic                 flush;
    logic                 valid;
    logic                 ready;
    logic [REG_ADDR-1:0]  rd;
    logic                 rd_wen;
    logic [1:0]           sel;
    logic [ISA_WIDTH-1:0] alu_res;
    logic [ISA_WIDTH-1:0] load_raw;
    logic [2:0]           load_f3;
    logic [ISA_WIDTH-1:0] csr_rdata;
    logic [ISA_WIDTH-1:0] pc;
    logic                 commit_valid;
    logic                 commit_ready;
    logic [ISA_WIDTH-1:0] commit_pc;
    logic                 rf_wen;
    logic [REG_ADDR-1:0]  rf_waddr;
    logic [ISA_WIDTH-1:0] rf_wdata;
    logic                 issue_fire;
    logic [REG_ADDR-1:0]  issue_rd;
    logic                 issue_wen;
    logic                 issue_ok;
    logic [REG_NUM-1:0]   busy;

    modport slave (
        input  flush, valid, rd, rd_wen, sel, alu_res, load_raw, load_f3, csr_rdata, pc,
        input  commit_ready, issue_fire, issue_rd, issue_wen,
        output ready, commit_valid, commit_pc, rf_wen, rf_waddr, rf_wdata, issue_ok, busy
    );

    modport master (
        output flush, valid, rd, rd_wen, sel, alu_res, load_raw, load_f3, csr_rdata, pc,
        output commit_ready, issue_fire, issue_rd, issue_wen,
        input  ready, commit_valid, commit_pc, rf_wen, rf_waddr, rf_wdata, issue_ok, busy
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: one-entry holding register in front of the GPR write port,
// plus per-register in-flight write counters used by IDU for RAW/WAW hazard checks.
module wb_stage #(
    parameter int ISA_WIDTH = 32,
    parameter int REG_ADDR  = 5,
    parameter int REG_NUM   = 32,
    parameter int SB_CNT_W  = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    wb_stage_if.slave bus
);
    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    logic                 held_valid;
    logic [REG_ADDR-1:0]  held_rd;
    logic                 held_wen;
    logic [ISA_WIDTH-1:0] held_pc;
    logic [ISA_WIDTH-1:0] held_data;

    logic                 ready;
    logic                 accept;
    logic                 fire;
    logic                 rf_wen;
    logic [ISA_WIDTH-1:0] load_shifted;
    logic [ISA_WIDTH-1:0] load_data;
    logic [ISA_WIDTH-1:0] sel_data;

    logic [SB_CNT_W-1:0]  cnt_q [REG_NUM];
    logic [SB_CNT_W-1:0]  cnt_d [REG_NUM];
    logic [REG_NUM-1:0]   inc_vec;
    logic [REG_NUM-1:0]   dec_vec;
    logic [REG_NUM-1:0]   busy_vec;

    // Handshakes: a transfer happens on a cycle where valid & ready are both high at the
    // rising edge; valid never depends on ready, and ready may depend on commit_ready.
    assign ready  = ~held_valid | bus.commit_ready;
    assign accept = bus.valid & ready;
    assign fire   = held_valid & bus.commit_ready;
    assign rf_wen = fire & held_wen & (held_rd != '0);

    always_comb begin
        load_shifted = bus.load_raw >> {bus.alu_res[1:0], 3'b000};
        load_data    = '0;
        case (bus.load_f3)
            3'b000:  load_data = {{(ISA_WIDTH-8){load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_data = {{(ISA_WIDTH-16){load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_data = bus.load_raw;
            3'b100:  load_data = {{(ISA_WIDTH-8){1'b0}}, load_shifted[7:0]};
            3'b101:  load_data = {{(ISA_WIDTH-16){1'b0}}, load_shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        sel_data = bus.alu_res;
        case (bus.sel)
            2'd0:    sel_data = bus.alu_res;
            2'd1:    sel_data = load_data;
            2'd2:    sel_data = bus.csr_rdata;
            default: sel_data = bus.pc + ISA_WIDTH'(4);
        endcase
    end

    // Flush wins over accept; a commit in the flush cycle still reaches the GPR file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= 1'b0;
            held_rd    <= '0;
            held_wen   <= 1'b0;
            held_pc    <= '0;
            held_data  <= '0;
        end else if (bus.flush) begin
            held_valid <= 1'b0;
        end else if (accept) begin
            held_valid <= 1'b1;
            held_rd    <= bus.rd;
            held_wen   <= bus.rd_wen;
            held_pc    <= bus.pc;
            held_data  <= sel_data;
        end else if (fire) begin
            held_valid <= 1'b0;
        end
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            inc_vec[r] = bus.issue_fire & bus.issue_wen & (bus.issue_rd == REG_ADDR'(r));
            dec_vec[r] = rf_wen & (held_rd == REG_ADDR'(r));
        end
    end

    // Simultaneous issue and retire to the same register cancel out.
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            cnt_d[r]    = cnt_q[r];
            busy_vec[r] = (cnt_q[r] != '0);
            if (inc_vec[r] && !dec_vec[r] && cnt_q[r] != CNT_MAX)
                cnt_d[r] = cnt_q[r] + 1'b1;
            else if (dec_vec[r] && !inc_vec[r] && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= '0;
        end else if (bus.flush) begin
            for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign bus.ready        = ready;
    assign bus.commit_valid = held_valid;
    assign bus.commit_pc    = held_pc;
    assign bus.rf_wen       = rf_wen;
    assign bus.rf_waddr     = held_rd;
    assign bus.rf_wdata     = held_data;
    assign bus.issue_ok     = (cnt_q[bus.issue_rd] != CNT_MAX);
    assign bus.busy         = busy_vec;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic, all outputs compared each
// cycle against a queue-based model of the held entry and an integer array of per-register counts.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if bus ();
    wb_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    // entry layout: {pc[69:38], wen[37], rd[36:32], data[31:0]}
    logic [69:0] exp_q[$];
    int          m_cnt[32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [31:0] alu,
                                             input logic [31:0] raw, input logic [2:0] f3,
                                             input logic [31:0] csr, input logic [31:0] pc);
        logic [31:0] b, h;
        int off;
        off = int'(alu % 4);
        b = (raw >> (8 * off)) & 32'hFF;
        h = (raw >> (8 * off)) & 32'hFFFF;
        case (sel)
            2'd0: return alu;
            2'd2: return csr;
            2'd3: return pc + 32'd4;
            default: begin
                case (f3)
                    3'd0: return b + ((b >= 128) ? 32'hFFFFFF00 : 32'h0);
                    3'd1: return h + ((h >= 32768) ? 32'hFFFF0000 : 32'h0);
                    3'd2: return raw;
                    3'd4: return b;
                    3'd5: return h;
                    default: return 32'h0;
                endcase
            end
        endcase
    endfunction

    task automatic set_idle();
        bus.flush = 0; bus.valid = 0; bus.rd = '0; bus.rd_wen = 0; bus.sel = '0;
        bus.alu_res = '0; bus.load_raw = '0; bus.load_f3 = '0; bus.csr_rdata = '0; bus.pc = '0;
        bus.commit_ready = 0; bus.issue_fire = 0; bus.issue_rd = '0; bus.issue_wen = 0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        foreach (m_cnt[r]) m_cnt[r] = 0;
    endtask

    task automatic model_check();
        logic [69:0] h;
        logic [31:0] busy_exp;
        bit hv;
        hv = (exp_q.size() > 0);
        check("ready", bus.ready, !hv || bus.commit_ready);
        check("commit_valid", bus.commit_valid, hv);
        if (hv) begin
            h = exp_q[0];
            check("rf_wen", bus.rf_wen, bus.commit_ready && h[37] && (h[36:32] != 0));
            check("rf_waddr", bus.rf_waddr, h[36:32]);
            check("rf_wdata", bus.rf_wdata, h[31:0]);
            check("commit_pc", bus.commit_pc, h[69:38]);
        end else begin
            check("rf_wen_idle", bus.rf_wen, 0);
        end
        foreach (m_cnt[r]) busy_exp[r] = (m_cnt[r] != 0);
        check("busy", bus.busy, busy_exp);
        check("issue_ok", bus.issue_ok, m_cnt[bus.issue_rd] != 3);
    endtask

    task automatic model_update();
        logic [69:0] h;
        int delta[32];
        int v;
        bit hv, fire, wr, acc;
        hv   = (exp_q.size() > 0);
        h    = hv ? exp_q[0] : '0;
        fire = hv && bus.commit_ready;
        wr   = fire && h[37] && (h[36:32] != 0);
        acc  = bus.valid && (!hv || bus.commit_ready);
        if (bus.flush) begin
            model_clear();
        end else begin
            foreach (delta[r]) delta[r] = 0;
            if (bus.issue_fire && bus.issue_wen && bus.issue_rd != 0) delta[bus.issue_rd] += 1;
            if (wr) delta[h[36:32]] -= 1;
            foreach (m_cnt[r]) begin
                v = m_cnt[r] + delta[r];
                m_cnt[r] = (v < 0) ? 0 : ((v > 3) ? 3 : v);
            end
            if (fire) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({bus.pc, bus.rd_wen, bus.rd,
                ref_data(bus.sel, bus.alu_res, bus.load_raw, bus.load_f3, bus.csr_rdata, bus.pc)});
        end
    endtask

    task automatic step();
        #1;
        model_check();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val, input bit cr);
        set_idle();
        bus.valid = 1; bus.sel = 2'd0; bus.alu_res = val; bus.rd = rd; bus.rd_wen = 1;
        bus.commit_ready = cr;
    endtask

    initial begin
        set_idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", bus.ready, 1);
        check("rst_commit_valid", bus.commit_valid, 0);
        check("rst_rf_wen", bus.rf_wen, 0);
        check("rst_busy", bus.busy, 32'h0);

        // issue rd=5, then accept and retire it
        set_idle(); bus.issue_fire = 1; bus.issue_rd = 5; bus.issue_wen = 1; step();
        set_idle(); #1 check("t1_busy5_set", bus.busy[5], 1);
        drive_alu(5, 32'h1234, 1); step();
        set_idle(); bus.commit_ready = 1;
        #1 check("t1_rf_wen", bus.rf_wen, 1);
        check("t1_waddr", bus.rf_waddr, 5);
        check("t1_wdata", bus.rf_wdata, 32'h1234);
        step();
        set_idle(); #1 check("t1_busy5_clr", bus.busy[5], 0);

        // load extraction, back to back
        set_idle(); bus.commit_ready = 1; bus.valid = 1; bus.sel = 2'd1; bus.rd = 3; bus.rd_wen = 1;
        bus.load_raw = 32'h80FF7F01; bus.alu_res = 32'h2; bus.load_f3 = 3'd0; step();
        bus.load_f3 = 3'd4; #1 check("lb", bus.rf_wdata, 32'hFFFFFFFF); step();
        bus.load_f3 = 3'd1; #1 check("lbu", bus.rf_wdata, 32'h000000FF); step();
        set_idle(); bus.commit_ready = 1; #1 check("lh", bus.rf_wdata, 32'hFFFF80FF); step();

        // backpressure then release with same-cycle accept
        drive_alu(9, 32'hAAAA0001, 0); step();
        set_idle();
        repeat (3) begin
            #1 check("bp_ready", bus.ready, 0);
            check("bp_rf_wen", bus.rf_wen, 0);
            check("bp_wdata", bus.rf_wdata, 32'hAAAA0001);
            step();
        end
        drive_alu(10, 32'h5555, 1);
        #1 check("rel_rf_wen", bus.rf_wen, 1);
        check("rel_ready", bus.ready, 1);
        check("rel_waddr", bus.rf_waddr, 9);
        step();
        set_idle(); #1 check("rel_next_valid", bus.commit_valid, 1);
        check("rel_next_wdata", bus.rf_wdata, 32'h5555);
        step();
        set_idle(); bus.commit_ready = 1; step();

        // x0 destination with PC+4
        set_idle(); bus.valid = 1; bus.rd = 0; bus.rd_wen = 1; bus.sel = 2'd3; bus.pc = 32'h80000000;
        step();
        set_idle(); bus.commit_ready = 1;
        #1 check("x0_commit_valid", bus.commit_valid, 1);
        check("x0_rf_wen", bus.rf_wen, 0);
        check("x0_wdata", bus.rf_wdata, 32'h80000004);
        check("x0_pc", bus.commit_pc, 32'h80000000);
        step();
        set_idle(); #1 check("x0_busy", bus.busy, 32'h0);

        // saturation, cancelling issue+commit, flush with commit in flight
        set_idle(); bus.issue_fire = 1; bus.issue_rd = 7; bus.issue_wen = 1;
        repeat (3) step();
        drive_alu(7, 32'h77, 0); bus.issue_rd = 7;
        #1 check("sat_issue_ok", bus.issue_ok, 0);
        step();
        set_idle(); bus.commit_ready = 1; bus.issue_fire = 1; bus.issue_rd = 7; bus.issue_wen = 1;
        #1 check("cancel_rf_wen", bus.rf_wen, 1);
        step();
        set_idle(); bus.issue_rd = 7;
        #1 check("cancel_issue_ok", bus.issue_ok, 0);
        check("cancel_busy7", bus.busy[7], 1);
        drive_alu(8, 32'h1, 0); step();
        set_idle(); bus.flush = 1; bus.commit_ready = 1; bus.valid = 1; bus.rd = 11; bus.rd_wen = 1;
        bus.issue_fire = 1; bus.issue_rd = 12; bus.issue_wen = 1;
        #1 check("flush_rf_wen", bus.rf_wen, 1);
        check("flush_waddr", bus.rf_waddr, 8);
        step();
        set_idle(); bus.issue_rd = 7;
        #1 check("flush_busy", bus.busy, 32'h0);
        check("flush_commit_valid", bus.commit_valid, 0);
        check("flush_issue_ok", bus.issue_ok, 1);
        step();

        // randomized traffic; IDU never fires on a saturated register
        repeat (2000) begin
            bus.valid        = ($urandom_range(0, 3) != 0);
            bus.rd           = 5'($urandom_range(0, 7));
            bus.rd_wen       = 1'($urandom_range(0, 1));
            bus.sel          = 2'($urandom_range(0, 3));
            bus.alu_res      = $urandom;
            bus.load_raw     = $urandom;
            bus.load_f3      = 3'($urandom_range(0, 7));
            bus.csr_rdata    = $urandom;
            bus.pc           = $urandom;
            bus.commit_ready = ($urandom_range(0, 3) != 0);
            bus.issue_rd     = 5'($urandom_range(0, 7));
            bus.issue_wen    = ($urandom_range(0, 3) != 0);
            bus.issue_fire   = ($urandom_range(0, 1) == 1) && (m_cnt[bus.issue_rd] != 3);
            bus.flush        = ($urandom_range(0, 63) == 0);
            step();
        end

        // async reset while an entry is held
        set_idle(); bus.commit_ready = 1; step();
        drive_alu(4, 32'h44, 0); bus.issue_fire = 1; bus.issue_rd = 4; bus.issue_wen = 1; step();
        set_idle(); bus.commit_ready = 1;
        #2 rst_n = 1'b0;
        #1 check("arst_commit_valid", bus.commit_valid, 0);
        check("arst_rf_wen", bus.rf_wen, 0);
        check("arst_ready", bus.ready, 1);
        check("arst_busy", bus.busy, 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
